// File: rtl/mips_encoder.sv
// mips_encoder: turns mnemonic-level requests into MIPS32 machine words.
// The li pseudo-instruction expands to one or two words (lui/ori). Encoded words
// are queued in a DEPTH-entry FIFO and presented on a valid/ready output.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high; clears FIFO, FSM and error state
//   req_*      request channel: valid/ready handshake, mnemonic code and fields
//   ins_*      output channel: FIFO head word with valid/ready handshake
//   err        sticky flag, set when an invalid code is accepted
//   err_cnt    saturating count of accepted invalid codes
module mips_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [5:0]    req_code,
  input  logic [4:0]    req_rs,
  input  logic [4:0]    req_rt,
  input  logic [4:0]    req_rd,
  input  logic [4:0]    req_shamt,
  input  logic [31:0]   req_imm,
  output logic          ins_valid,
  input  logic          ins_ready,
  output logic [31:0]   ins_word,
  output logic          err,
  output logic [CW-1:0] err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LI2  = 1'b1;

  localparam logic [5:0] CODE_LI = 6'd54;

  function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  logic [0:0]    state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_d;
  logic [4:0]    li_rt;
  logic [15:0]   li_lo;

  logic [31:0] enc_word, push_word;
  logic        enc_ok, accept, li_split, li_push, push, pop;

  logic [15:0] imm16, imm_hi;
  assign imm16  = req_imm[15:0];
  assign imm_hi = req_imm[31:16];

  // Word for the current request; for li this is the first (or only) word.
  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b1;
    case (req_code)
      6'd0:  enc_word = '0;
      6'd1:  enc_word = i_op(6'h20, req_rs, req_rt, imm16);
      6'd2:  enc_word = i_op(6'h24, req_rs, req_rt, imm16);
      6'd3:  enc_word = i_op(6'h21, req_rs, req_rt, imm16);
      6'd4:  enc_word = i_op(6'h25, req_rs, req_rt, imm16);
      6'd5:  enc_word = i_op(6'h23, req_rs, req_rt, imm16);
      6'd6:  enc_word = i_op(6'h28, req_rs, req_rt, imm16);
      6'd7:  enc_word = i_op(6'h29, req_rs, req_rt, imm16);
      6'd8:  enc_word = i_op(6'h2B, req_rs, req_rt, imm16);
      6'd9:  enc_word = r_op(req_rs, req_rt, req_rd, 5'd0, 6'h20);
      6'd10: enc_word = r_op(req_rs, req_rt, req_rd, 5'd0, 6'h21);
      6'd11: enc_word = r_op(req_rs, req_rt, req_rd, 5'd0, 6'h22);
      6'd12: enc_word = r_op(req_rs, req_rt, req_rd, 5'd0, 6'h23);
      6'd13: enc_word = r_op(req_rs, req_rt, 5'd0, 5'd0, 6'h18);
      6'd14: enc_word = r_op(req_rs, req_rt, 5'd0, 5'd0, 6'h19);
      6'd15: enc_word = r_op(req_rs, req_rt, 5'd0, 5'd0, 6'h1A);
      6'd16: enc_word = r_op(req_rs, req_rt, 5'd0, 5'd0, 6'h1B);
      6'd17: enc_word = r_op(5'd0, req_rt, req_rd, req_shamt, 6'h00);
      6'd18: enc_word = r_op(5'd0, req_rt, req_rd, req_shamt, 6'h02);
      6'd19: enc_word = r_op(5'd0, req_rt, req_rd, req_shamt, 6'h03);
      6'd20: enc_word = r_op(req_rs, req_rt, req_rd, 5'd0, 6'h04);
      6'd21: enc_word = r_op(req_rs, req_rt, req_rd, 5'd0, 6'h06);
      6'd22: enc_word = r_op(req_rs, req_rt, req_rd, 5'd0, 6'h07);
      6'd23: enc_word = r_op(req_rs, req_rt, req_rd, 5'd0, 6'h24);
      6'd24: enc_word = r_op(req_rs, req_rt, req_rd, 5'd0, 6'h25);
      6'd25: enc_word = r_op(req_rs, req_rt, req_rd, 5'd0, 6'h26);
      6'd26: enc_word = r_op(req_rs, req_rt, req_rd, 5'd0, 6'h27);
      6'd27: enc_word = r_op(req_rs, req_rt, req_rd, 5'd0, 6'h2A);
      6'd28: enc_word = r_op(req_rs, req_rt, req_rd, 5'd0, 6'h2B);
      6'd29: enc_word = i_op(6'h08, req_rs, req_rt, imm16);
      6'd30: enc_word = i_op(6'h09, req_rs, req_rt, imm16);
      6'd31: enc_word = i_op(6'h0C, req_rs, req_rt, imm16);
      6'd32: enc_word = i_op(6'h0D, req_rs, req_rt, imm16);
      6'd33: enc_word = i_op(6'h0E, req_rs, req_rt, imm16);
      6'd34: enc_word = i_op(6'h0F, 5'd0, req_rt, imm16);
      6'd35: enc_word = i_op(6'h0A, req_rs, req_rt, imm16);
      6'd36: enc_word = i_op(6'h0B, req_rs, req_rt, imm16);
      6'd37: enc_word = i_op(6'h04, req_rs, req_rt, imm16);
      6'd38: enc_word = i_op(6'h05, req_rs, req_rt, imm16);
      6'd39: enc_word = i_op(6'h06, req_rs, 5'd0, imm16);
      6'd40: enc_word = i_op(6'h07, req_rs, 5'd0, imm16);
      6'd41: enc_word = i_op(6'h01, req_rs, 5'd0, imm16);  // REGIMM bltz
      6'd42: enc_word = i_op(6'h01, req_rs, 5'd1, imm16);  // REGIMM bgez
      6'd43: enc_word = {6'h02, req_imm[25:0]};
      6'd44: enc_word = {6'h03, req_imm[25:0]};
      6'd45: enc_word = r_op(req_rs, 5'd0, req_rd, 5'd0, 6'h09);
      6'd46: enc_word = r_op(req_rs, 5'd0, 5'd0, 5'd0, 6'h08);
      6'd47: enc_word = r_op(5'd0, 5'd0, req_rd, 5'd0, 6'h10);
      6'd48: enc_word = r_op(5'd0, 5'd0, req_rd, 5'd0, 6'h12);
      6'd49: enc_word = r_op(req_rs, 5'd0, 5'd0, 5'd0, 6'h11);
      6'd50: enc_word = r_op(req_rs, 5'd0, 5'd0, 5'd0, 6'h13);
      6'd51: enc_word = 32'h4200_0018;
      6'd52: enc_word = {6'h10, 5'd0, req_rt, req_rd, 11'd0};
      6'd53: enc_word = {6'h10, 5'd4, req_rt, req_rd, 11'd0};
      // li: a value that fits in 16 zero-extended bits needs only ori from $0.
      6'd54: enc_word = (imm_hi == 16'd0) ? i_op(6'h0D, 5'd0, req_rt, imm16)
                                          : i_op(6'h0F, 5'd0, req_rt, imm_hi);
      default: enc_ok = 1'b0;
    endcase
  end

  assign req_ready = !reset && (state == IDLE) && (count < FULL);
  assign accept    = req_valid && req_ready;
  assign li_split  = accept && (req_code == CODE_LI) && (imm_hi != 16'd0) && (imm16 != 16'd0);
  // Only the registered count gates the ori; a same-cycle pop is not forwarded.
  assign li_push   = (state == LI2) && (count < FULL);
  assign push      = (accept && enc_ok) || li_push;
  assign pop       = ins_valid && ins_ready;
  assign push_word = (state == LI2) ? i_op(6'h0D, li_rt, li_rt, li_lo) : enc_word;
  assign count_d   = count + (AW+1)'(push) - (AW+1)'(pop);

  assign ins_valid = (count != '0);
  assign ins_word  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      li_rt   <= '0;
      li_lo   <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_d;

      if (accept && !enc_ok) begin
        err <= 1'b1;
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + CW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (li_split) begin
            state <= LI2;
            li_rt <= req_rt;
            li_lo <= imm16;
          end
        end
        default: begin
          if (li_push) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
